// File: rtl/ysyx22040413_core_fsm.sv
// Multi-cycle RV64 sequencer: owns PC/IR, fetch and data-memory handshakes, writeback gating,
// ack timeouts, misaligned-target trap and ebreak halt.
module ysyx22040413_core_fsm #(
  parameter logic [63:0] PC_RESET = 64'h8000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_if_req,
  output logic [63:0] o_if_addr,
  input  logic        i_if_ack,
  input  logic [31:0] i_if_rdata,
  output logic [63:0] o_pc,
  output logic [31:0] o_inst,
  input  logic        i_dec_rdwen,
  input  logic        i_dec_pc_update,
  input  logic        i_dec_jalr,
  input  logic        i_dec_store,
  input  logic        i_dec_halt,
  input  logic [63:0] i_alu_result,
  input  logic [63:0] i_pc_op1,
  input  logic [63:0] i_pc_op2,
  input  logic [63:0] i_store_data,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  input  logic        i_mem_ack,
  output logic        o_rf_wen,
  output logic [63:0] o_rf_wdata,
  output logic [63:0] o_retired,
  output logic        o_halted,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [63:0] r_pc;
  logic [31:0] r_inst;
  logic [63:0] r_wb_data;
  logic [63:0] r_target;
  logic [63:0] r_store_data;
  logic [63:0] r_retired;
  logic        r_rdwen;
  logic        r_pc_update;
  logic [7:0]  r_wait;

  logic [63:0] w_jump_sum;
  logic [63:0] w_next_pc;
  logic        w_pc_ok;
  logic        w_timeout;
  logic        w_waiting;

  assign w_jump_sum = i_pc_op1 + i_pc_op2;
  assign w_next_pc  = r_pc_update ? r_target : r_pc + 64'd4;
  assign w_pc_ok    = (w_next_pc[1:0] == 2'b00);
  assign w_timeout  = (r_wait == TIMEOUT);
  // Counter runs only while a request is outstanding, so it is already zero on entry to FETCH/MEM.
  assign w_waiting  = ((r_state == S_FETCH) && !i_if_ack) ||
                      ((r_state == S_MEM)   && !i_mem_ack);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (i_if_ack)       w_next_state = S_DECODE;
        else if (w_timeout) w_next_state = S_ERR;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC: begin
        if (i_dec_halt)       w_next_state = S_HALT;
        else if (i_dec_store) w_next_state = S_MEM;
        else                  w_next_state = S_WB;
      end
      S_MEM: begin
        if (i_mem_ack)      w_next_state = S_WB;
        else if (w_timeout) w_next_state = S_ERR;
      end
      S_WB:     w_next_state = w_pc_ok ? S_FETCH : S_ERR;
      S_HALT:   w_next_state = S_HALT;
      S_ERR:    w_next_state = S_ERR;
      default:  w_next_state = S_ERR;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_FETCH;
      r_pc         <= PC_RESET;
      r_inst       <= 32'h0000_0013;
      r_wb_data    <= '0;
      r_target     <= '0;
      r_store_data <= '0;
      r_retired    <= '0;
      r_rdwen      <= 1'b0;
      r_pc_update  <= 1'b0;
      r_wait       <= '0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_waiting ? r_wait + 8'd1 : 8'd0;
      if ((r_state == S_FETCH) && i_if_ack) begin
        r_inst <= i_if_rdata;
      end
      if (r_state == S_EXEC) begin
        r_wb_data    <= i_alu_result;
        r_target     <= {w_jump_sum[63:1], w_jump_sum[0] & ~i_dec_jalr};
        r_store_data <= i_store_data;
        r_rdwen      <= i_dec_rdwen;
        r_pc_update  <= i_dec_pc_update;
      end
      if ((r_state == S_WB) && w_pc_ok) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 64'd1;
      end
    end
  end

  // Fetch and writeback are masked while reset is held so nothing escapes before the core restarts.
  assign o_if_req    = (r_state == S_FETCH) && !i_rst;
  assign o_if_addr   = r_pc;
  assign o_pc        = r_pc;
  assign o_inst      = r_inst;
  assign o_mem_req   = (r_state == S_MEM);
  assign o_mem_we    = (r_state == S_MEM);
  assign o_mem_addr  = r_wb_data;
  assign o_mem_wdata = r_store_data;
  assign o_rf_wen    = (r_state == S_WB) && r_rdwen && w_pc_ok && !i_rst;
  assign o_rf_wdata  = r_wb_data;
  assign o_retired   = r_retired;
  assign o_halted    = (r_state == S_HALT);
  assign o_err       = (r_state == S_ERR);

endmodule

// File: tb/tb_ysyx22040413_core_fsm.sv
// Bench for ysyx22040413_core_fsm: acts as fetch/data memory and decoder, compares each
// instruction against a transaction-level model of PC, retire count, latency and side effects.
module tb_ysyx22040413_core_fsm;
  localparam logic [63:0] PC_RESET = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_req, if_ack = 1'b0;
  logic [63:0] if_addr, pc;
  logic [31:0] if_rdata = 32'h0, inst;
  logic dec_rdwen = 0, dec_pc_update = 0, dec_jalr = 0, dec_store = 0, dec_halt = 0;
  logic [63:0] alu_result = '0, pc_op1 = '0, pc_op2 = '0, store_data = '0;
  logic mem_req, mem_we, mem_ack = 1'b0;
  logic [63:0] mem_addr, mem_wdata;
  logic rf_wen;
  logic [63:0] rf_wdata, retired;
  logic halted, err;

  int n_vec = 0;
  int n_bad = 0;

  // model state
  logic [63:0] m_pc;
  logic [63:0] m_retired;

  // observations of the last run_instr
  int obs_cycles, obs_rf_cnt, obs_mem_cycles;
  logic [63:0] obs_rf_data, obs_mem_addr, obs_mem_data, obs_if_addr;
  bit obs_mem_stable, obs_if_stable, obs_done;

  ysyx22040413_core_fsm #(.PC_RESET(PC_RESET), .TIMEOUT(8'd255)) dut (
    .i_clk(clk), .i_rst(rst),
    .o_if_req(if_req), .o_if_addr(if_addr), .i_if_ack(if_ack), .i_if_rdata(if_rdata),
    .o_pc(pc), .o_inst(inst),
    .i_dec_rdwen(dec_rdwen), .i_dec_pc_update(dec_pc_update), .i_dec_jalr(dec_jalr),
    .i_dec_store(dec_store), .i_dec_halt(dec_halt),
    .i_alu_result(alu_result), .i_pc_op1(pc_op1), .i_pc_op2(pc_op2), .i_store_data(store_data),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack),
    .o_rf_wen(rf_wen), .o_rf_wdata(rf_wdata), .o_retired(retired),
    .o_halted(halted), .o_err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d vectors want completion", n_vec);
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; if_ack = 1'b0; mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_pc = PC_RESET; m_retired = '0;
  endtask

  // Plays memory for one instruction; ends at the next fetch, or on err/halted.
  task automatic run_instr(input bit wen, input bit pcu, input bit jalr, input bit st, input bit hlt,
                           input logic [63:0] alu, input logic [63:0] op1, input logic [63:0] op2,
                           input logic [63:0] sd, input logic [31:0] ins,
                           input int fd, input int md, input int budget);
    int fw, mw;
    bit fetched;
    dec_rdwen = wen; dec_pc_update = pcu; dec_jalr = jalr; dec_store = st; dec_halt = hlt;
    alu_result = alu; pc_op1 = op1; pc_op2 = op2; store_data = sd;
    fw = 0; mw = 0; fetched = 0;
    obs_cycles = 0; obs_rf_cnt = 0; obs_mem_cycles = 0; obs_done = 0;
    obs_rf_data = '0; obs_mem_addr = '0; obs_mem_data = '0; obs_if_addr = '1;
    obs_mem_stable = 1; obs_if_stable = 1;
    for (int c = 0; c < budget; c++) begin
      #1;
      if_ack = 1'b0; mem_ack = 1'b0;
      if ((if_req && fetched) || err || halted) begin
        obs_done = 1;
        break;
      end
      if (if_req) begin
        if (fw == 0) obs_if_addr = if_addr;
        else if (if_addr !== obs_if_addr) obs_if_stable = 0;
        if (fw == fd) begin if_ack = 1'b1; if_rdata = ins; fetched = 1; end
        fw++;
      end
      if (mem_req) begin
        if (mw == 0) begin obs_mem_addr = mem_addr; obs_mem_data = mem_wdata; end
        else if (mem_addr !== obs_mem_addr || mem_wdata !== obs_mem_data) obs_mem_stable = 0;
        if (mem_we !== 1'b1) obs_mem_stable = 0;
        if (mw == md) mem_ack = 1'b1;
        mw++;
        obs_mem_cycles++;
      end
      if (rf_wen) begin obs_rf_cnt++; obs_rf_data = rf_wdata; end
      obs_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_vec++; if (if_req !== 1'b0) begin n_bad++; $display("FAIL reset_if_req got=%b want=0", if_req); end
    n_vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got=%b%b want=00", mem_req, mem_we); end
    n_vec++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL reset_rf_wen got=%b want=0", rf_wen); end
    n_vec++; if (pc !== PC_RESET) begin n_bad++; $display("FAIL reset_pc got=%0h want=%0h", pc, PC_RESET); end
    n_vec++; if (inst !== 32'h0000_0013) begin n_bad++; $display("FAIL reset_inst got=%0h want=13", inst); end
    n_vec++; if (retired !== 64'd0) begin n_bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
    n_vec++; if (halted !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got=%b%b want=00", halted, err); end
    n_vec++; if (mem_addr !== 64'd0 || rf_wdata !== 64'd0) begin n_bad++; $display("FAIL reset_latches got=%0h/%0h want=0/0", mem_addr, rf_wdata); end
    rst = 1'b0;
    m_pc = PC_RESET; m_retired = '0;
  endtask

  task automatic test_addi();
    run_instr(1, 0, 0, 0, 0, 64'd1, '0, '0, '0, 32'h0010_0093, 0, 0, 20);
    n_vec++; if (obs_if_addr !== 64'h8000_0000) begin n_bad++; $display("FAIL addi_if_addr got=%0h want=80000000", obs_if_addr); end
    n_vec++; if (obs_cycles !== 4) begin n_bad++; $display("FAIL addi_cycles got=%0d want=4", obs_cycles); end
    n_vec++; if (obs_rf_cnt !== 1 || obs_rf_data !== 64'd1) begin n_bad++; $display("FAIL addi_rf got=%0d/%0h want=1/1", obs_rf_cnt, obs_rf_data); end
    n_vec++; if (pc !== 64'h8000_0004 || retired !== 64'd1) begin n_bad++; $display("FAIL addi_commit got=%0h/%0d want=80000004/1", pc, retired); end
    n_vec++; if (inst !== 32'h0010_0093) begin n_bad++; $display("FAIL addi_inst got=%0h want=00100093", inst); end
    m_pc = 64'h8000_0004; m_retired = 1;
  endtask

  task automatic test_jalr();
    run_instr(1, 1, 1, 0, 0, 64'h8000_0008, 64'h8000_0101, 64'd4, '0, 32'h0000_80e7, 0, 0, 20);
    n_vec++; if (pc !== 64'h8000_0104) begin n_bad++; $display("FAIL jalr_pc got=%0h want=80000104", pc); end
    n_vec++; if (obs_rf_cnt !== 1 || obs_rf_data !== 64'h8000_0008) begin n_bad++; $display("FAIL jalr_rf got=%0d/%0h want=1/80000008", obs_rf_cnt, obs_rf_data); end
    n_vec++; if (retired !== 64'd2) begin n_bad++; $display("FAIL jalr_retired got=%0d want=2", retired); end
    m_pc = 64'h8000_0104; m_retired = 2;
  endtask

  task automatic test_store_delayed();
    run_instr(0, 0, 0, 1, 0, 64'h8000_1000, '0, '0, 64'hDEAD_BEEF, 32'h0020_b023, 0, 3, 30);
    n_vec++; if (obs_mem_cycles !== 4) begin n_bad++; $display("FAIL store_mem_cycles got=%0d want=4", obs_mem_cycles); end
    n_vec++; if (obs_mem_addr !== 64'h8000_1000 || obs_mem_data !== 64'hDEAD_BEEF) begin n_bad++; $display("FAIL store_mem_payload got=%0h/%0h want=80001000/deadbeef", obs_mem_addr, obs_mem_data); end
    n_vec++; if (obs_mem_stable !== 1) begin n_bad++; $display("FAIL store_mem_stable got=%b want=1", obs_mem_stable); end
    n_vec++; if (obs_rf_cnt !== 0) begin n_bad++; $display("FAIL store_rf_wen got=%0d want=0", obs_rf_cnt); end
    n_vec++; if (obs_cycles !== 8) begin n_bad++; $display("FAIL store_cycles got=%0d want=8", obs_cycles); end
    n_vec++; if (pc !== 64'h8000_0108 || retired !== 64'd3) begin n_bad++; $display("FAIL store_commit got=%0h/%0d want=80000108/3", pc, retired); end
    m_pc = 64'h8000_0108; m_retired = 3;
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      int kind, fd, md, exp_cycles;
      bit wen, pcu, jalr, st;
      logic [63:0] alu, op1, op2, sd, tgt, exp_pc;
      kind = $urandom_range(0, 3); fd = $urandom_range(0, 3); md = $urandom_range(0, 3);
      alu = {$urandom, $urandom}; sd = {$urandom, $urandom};
      op1 = {$urandom, $urandom}; op2 = {$urandom, $urandom};
      wen = 1; pcu = 0; jalr = 0; st = 0;
      case (kind)
        1: begin pcu = 1; wen = $urandom_range(0, 1); op1 = op1 & ~64'h3; op2 = op2 & ~64'h3; end
        2: begin
          pcu = 1; jalr = 1;
          tgt = {$urandom, $urandom} & ~64'h3;
          op2 = tgt - op1 + 64'($urandom_range(0, 1));
        end
        3: begin st = 1; wen = 0; end
        default: ;
      endcase
      if (!pcu)      exp_pc = m_pc + 64'd4;
      else if (jalr) exp_pc = (op1 + op2) & ~64'h1;
      else           exp_pc = op1 + op2;
      exp_cycles = 4 + fd + (st ? 1 + md : 0);
      run_instr(wen, pcu, jalr, st, 0, alu, op1, op2, sd, $urandom, fd, md, 50);
      n_vec++; if (obs_done !== 1 || obs_cycles !== exp_cycles) begin n_bad++; $display("FAIL rnd%0d_cycles got=%0d want=%0d", k, obs_cycles, exp_cycles); end
      n_vec++; if (obs_if_addr !== m_pc || obs_if_stable !== 1) begin n_bad++; $display("FAIL rnd%0d_if_addr got=%0h want=%0h", k, obs_if_addr, m_pc); end
      n_vec++; if (obs_rf_cnt !== int'(wen)) begin n_bad++; $display("FAIL rnd%0d_rf_cnt got=%0d want=%0d", k, obs_rf_cnt, wen); end
      if (wen) begin
        n_vec++; if (obs_rf_data !== alu) begin n_bad++; $display("FAIL rnd%0d_rf_data got=%0h want=%0h", k, obs_rf_data, alu); end
      end
      n_vec++; if (obs_mem_cycles !== (st ? md + 1 : 0)) begin n_bad++; $display("FAIL rnd%0d_mem_cycles got=%0d want=%0d", k, obs_mem_cycles, st ? md + 1 : 0); end
      if (st) begin
        n_vec++; if (obs_mem_addr !== alu || obs_mem_data !== sd || obs_mem_stable !== 1) begin n_bad++; $display("FAIL rnd%0d_mem got=%0h/%0h want=%0h/%0h", k, obs_mem_addr, obs_mem_data, alu, sd); end
      end
      n_vec++; if (pc !== exp_pc || retired !== m_retired + 1) begin n_bad++; $display("FAIL rnd%0d_commit got=%0h/%0d want=%0h/%0d", k, pc, retired, exp_pc, m_retired + 1); end
      m_pc = exp_pc; m_retired = m_retired + 1;
    end
  endtask

  task automatic test_halt();
    int reqs, wens;
    run_instr(1, 0, 0, 1, 1, 64'h1234, '0, '0, '0, 32'h0010_0073, 1, 0, 20);
    n_vec++; if (obs_done !== 1 || obs_cycles !== 4 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_entry got=%0d/%b want=4/1", obs_cycles, halted); end
    reqs = 0; wens = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if_ack = $urandom_range(0, 1); mem_ack = $urandom_range(0, 1);
      if (if_req || mem_req) reqs++;
      if (rf_wen) wens++;
      @(negedge clk);
    end
    if_ack = 1'b0; mem_ack = 1'b0;
    #1;
    n_vec++; if (reqs !== 0 || wens !== 0) begin n_bad++; $display("FAIL halt_quiet got=%0d/%0d want=0/0", reqs, wens); end
    n_vec++; if (pc !== m_pc || retired !== m_retired || halted !== 1'b1) begin n_bad++; $display("FAIL halt_frozen got=%0h/%0d/%b want=%0h/%0d/1", pc, retired, halted, m_pc, m_retired); end
  endtask

  task automatic test_rst_mid_mem();
    int mw;
    do_reset();
    run_instr(1, 0, 0, 0, 0, 64'd7, '0, '0, '0, 32'h0070_0093, 0, 0, 20);
    dec_rdwen = 0; dec_store = 1; dec_halt = 0; dec_pc_update = 0;
    alu_result = 64'h8000_2000; store_data = 64'h55;
    mw = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if_ack = if_req; if_rdata = 32'h0000_3023; mem_ack = 1'b0;
      if (mem_req) mw++;
      if (mw == 3) begin rst = 1'b1; break; end
      @(negedge clk);
    end
    if_ack = 1'b0;
    @(negedge clk); #1;
    n_vec++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || if_req !== 1'b0) begin n_bad++; $display("FAIL rstmem_req got=%b%b%b want=000", mem_req, mem_we, if_req); end
    n_vec++; if (pc !== PC_RESET || retired !== 64'd0 || halted !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rstmem_state got=%0h/%0d/%b%b want=%0h/0/00", pc, retired, halted, err, PC_RESET); end
    rst = 1'b0;
    m_pc = PC_RESET; m_retired = '0;
    run_instr(1, 0, 0, 0, 0, 64'd9, '0, '0, '0, 32'h0090_0093, 0, 0, 20);
    n_vec++; if (obs_if_addr !== PC_RESET || obs_cycles !== 4 || pc !== PC_RESET + 64'd4) begin n_bad++; $display("FAIL rstmem_resume got=%0h/%0d/%0h want=%0h/4/%0h", obs_if_addr, obs_cycles, pc, PC_RESET, PC_RESET + 64'd4); end
  endtask

  task automatic test_misaligned();
    int reqs;
    do_reset();
    run_instr(1, 1, 0, 0, 0, 64'h77, PC_RESET, 64'd2, '0, 32'h0020_006f, 0, 0, 20);
    n_vec++; if (err !== 1'b1 || obs_cycles !== 4) begin n_bad++; $display("FAIL misalign_err got=%b/%0d want=1/4", err, obs_cycles); end
    n_vec++; if (obs_rf_cnt !== 0 || pc !== PC_RESET || retired !== 64'd0) begin n_bad++; $display("FAIL misalign_nocommit got=%0d/%0h/%0d want=0/%0h/0", obs_rf_cnt, pc, retired, PC_RESET); end
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      #1; if (if_req || mem_req || rf_wen) reqs++;
      @(negedge clk);
    end
    n_vec++; if (reqs !== 0 || err !== 1'b1) begin n_bad++; $display("FAIL misalign_quiet got=%0d/%b want=0/1", reqs, err); end
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    run_instr(1, 0, 0, 0, 0, 64'd1, '0, '0, '0, 32'h13, 1000, 0, 400);
    n_vec++; if (obs_done !== 1 || obs_cycles !== 256 || err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got=%0d/%b want=256/1", obs_cycles, err); end
    n_vec++; if (pc !== PC_RESET || retired !== 64'd0) begin n_bad++; $display("FAIL timeout_state got=%0h/%0d want=%0h/0", pc, retired, PC_RESET); end
  endtask

  task automatic test_ack_at_limit();
    do_reset();
    run_instr(1, 0, 0, 0, 0, 64'd3, '0, '0, '0, 32'h0030_0093, 255, 0, 400);
    n_vec++; if (obs_done !== 1 || obs_cycles !== 259 || err !== 1'b0) begin n_bad++; $display("FAIL acklimit_cycles got=%0d/%b want=259/0", obs_cycles, err); end
    n_vec++; if (pc !== PC_RESET + 64'd4 || retired !== 64'd1 || obs_rf_data !== 64'd3) begin n_bad++; $display("FAIL acklimit_commit got=%0h/%0d/%0h want=%0h/1/3", pc, retired, obs_rf_data, PC_RESET + 64'd4); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_jalr();
    test_store_delayed();
    test_random(40);
    test_halt();
    test_rst_mid_mem();
    test_misaligned();
    test_fetch_timeout();
    test_ack_at_limit();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
